key_debounce: RTL and testbench

- Input conditioning stage directly upstream of the special-function-register block; drives its 13-bit `keys` input.
- Synchronises raw push-button/switch lines, debounces each line independently on a prescaled tick, and presents clean levels.
- Also produces one-cycle press/release event pulses and an aggregate event pulse, usable as an interrupt source.

---
 rtl/key_debounce.sv | 78 +++++++
 tb/tb_key_debounce.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Key input conditioner: two-flop synchroniser, shared debounce prescaler and
// per-key qualification counters producing clean levels plus press/release pulses.
module key_debounce #(
    parameter int NKEYS      = 13,
    parameter int PRESCALE   = 50000,
    parameter int STABLE     = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [NKEYS-1:0] keys_raw,
    output logic [NKEYS-1:0] keys,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic             any_event,
    output logic             tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [NKEYS-1:0] RELEASED = (ACTIVE_LOW != 0) ? {NKEYS{1'b1}} : {NKEYS{1'b0}};

    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [NKEYS-1:0] sample;
    logic [NKEYS-1:0] differ;
    logic [NKEYS-1:0] at_max;
    logic [NKEYS-1:0] accept;
    logic [PW-1:0]    pre_cnt;
    logic [CW-1:0]    cnt [NKEYS];

    // XOR with the released level turns every line into 1 = pressed.
    assign sample = sync2 ^ RELEASED;
    assign tick   = (pre_cnt == PW'(PRESCALE - 1));

    always_comb begin
        differ = '0;
        at_max = '0;
        for (int k = 0; k < NKEYS; k++) begin
            differ[k] = sample[k] ^ keys[k];
            at_max[k] = (cnt[k] == CW'(STABLE - 1));
        end
    end

    assign accept = differ & at_max & {NKEYS{tick}};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync1       <= RELEASED;
            sync2       <= RELEASED;
            pre_cnt     <= '0;
            keys        <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_event   <= 1'b0;
            for (int k = 0; k < NKEYS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1       <= keys_raw;
            sync2       <= sync1;
            pre_cnt     <= tick ? '0 : pre_cnt + PW'(1);
            keys        <= (keys & ~accept) | (sample & accept);
            key_press   <= accept & sample;
            key_release <= accept & ~sample;
            any_event   <= |accept;
            // Any cycle matching the accepted level restarts qualification.
            for (int k = 0; k < NKEYS; k++) begin
                if (!differ[k]) begin
                    cnt[k] <= '0;
                end else if (tick) begin
                    cnt[k] <= accept[k] ? '0 : cnt[k] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: vector table for clean transitions plus
// hand sequences for bouncing, mid-qualification reset and a 1-cycle glitch.
module tb_key_debounce;

    localparam int NK          = 13;
    localparam int PRESCALE_TB = 4;
    localparam int STABLE_TB   = 3;
    localparam logic [NK-1:0] IDLE = 13'h1FFF;

    logic          clk = 1'b0;
    logic          nreset;
    logic [NK-1:0] raw0, raw1;
    logic [NK-1:0] keys0, press0, rel0;
    logic [NK-1:0] keys1, press1, rel1;
    logic          any0, tick0, any1, tick1;

    int total = 0;
    int bad   = 0;
    int model_pre = 0;
    bit model_tick = 1'b0;
    int n_since = 0;
    int ticks_seen = 0;

    typedef struct {
        logic [NK-1:0] raw;
        logic [NK-1:0] exp_keys;
        logic [NK-1:0] exp_press;
        logic [NK-1:0] exp_rel;
    } vec_t;

    vec_t vecs [7];

    key_debounce #(.NKEYS(NK), .PRESCALE(PRESCALE_TB), .STABLE(STABLE_TB), .ACTIVE_LOW(1)) dut0 (
        .clk(clk), .nreset(nreset), .keys_raw(raw0), .keys(keys0), .key_press(press0),
        .key_release(rel0), .any_event(any0), .tick(tick0)
    );

    key_debounce #(.NKEYS(NK), .PRESCALE(1), .STABLE(1), .ACTIVE_LOW(1)) dut1 (
        .clk(clk), .nreset(nreset), .keys_raw(raw1), .keys(keys1), .key_press(press1),
        .key_release(rel1), .any_event(any1), .tick(tick1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // One clock; the prescaler model tracks which posedges carry a tick for dut0.
    task automatic advance();
        @(posedge clk);
        if (!nreset) begin
            model_pre  = 0;
            model_tick = 1'b0;
        end else begin
            model_tick = (model_pre == PRESCALE_TB - 1);
            model_pre  = model_tick ? 0 : model_pre + 1;
        end
        n_since++;
        if (n_since >= 3 && model_tick) ticks_seen++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NK-1:0] value);
        raw0       = value;
        n_since    = 0;
        ticks_seen = 0;
    endtask

    task automatic expectAccept(input string name, input logic [NK-1:0] prev_keys,
                                input logic [NK-1:0] exp_keys, input logic [NK-1:0] exp_press,
                                input logic [NK-1:0] exp_rel);
        bit quiet = 1'b1;
        while (ticks_seen < STABLE_TB && n_since < 40) begin
            advance();
            if (ticks_seen < STABLE_TB &&
                (keys0 !== prev_keys || press0 !== '0 || rel0 !== '0 || any0 !== 1'b0))
                quiet = 1'b0;
        end
        if (ticks_seen < STABLE_TB) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout actual=%0d ticks expected=%0d", name, ticks_seen, STABLE_TB);
        end
        checkOutput({name, "_quiet"}, 32'(quiet), 32'd1);
        checkOutput({name, "_keys"}, 32'(keys0), 32'(exp_keys));
        checkOutput({name, "_press"}, 32'(press0), 32'(exp_press));
        checkOutput({name, "_release"}, 32'(rel0), 32'(exp_rel));
        checkOutput({name, "_any"}, 32'(any0), 32'd1);
        advance();
        checkOutput({name, "_after_keys"}, 32'(keys0), 32'(exp_keys));
        checkOutput({name, "_after_pulses"}, 32'({press0, rel0, any0}), 32'd0);
    endtask

    initial begin
        int tick_errs;
        int tick_cnt;
        bit quiet;
        logic [NK-1:0] prev;

        vecs[0] = '{IDLE & ~13'h0020, 13'h0020, 13'h0020, 13'h0000};
        vecs[1] = '{IDLE,             13'h0000, 13'h0000, 13'h0020};
        vecs[2] = '{IDLE & ~13'h1001, 13'h1001, 13'h1001, 13'h0000};
        vecs[3] = '{IDLE,             13'h0000, 13'h0000, 13'h1001};
        vecs[4] = '{IDLE & ~13'h0006, 13'h0006, 13'h0006, 13'h0000};
        vecs[5] = '{IDLE & ~13'h000C, 13'h000C, 13'h0008, 13'h0002};
        vecs[6] = '{IDLE,             13'h0000, 13'h0000, 13'h000C};

        nreset = 1'b0;
        raw0   = IDLE;
        raw1   = IDLE;
        @(negedge clk);
        advance();
        advance();
        checkOutput("reset_keys", 32'(keys0), 32'd0);
        checkOutput("reset_pulses", 32'({press0, rel0, any0}), 32'd0);
        checkOutput("reset_tick", 32'(tick0), 32'd0);

        // Idle after reset release: no events, tick every fourth cycle.
        nreset    = 1'b1;
        tick_errs = 0;
        tick_cnt  = 0;
        quiet     = 1'b1;
        for (int i = 0; i < 100; i++) begin
            advance();
            if (tick0 !== (model_pre == PRESCALE_TB - 1)) tick_errs++;
            if (tick0 === 1'b1) tick_cnt++;
            if (keys0 !== '0 || press0 !== '0 || rel0 !== '0 || any0 !== 1'b0) quiet = 1'b0;
        end
        checkOutput("idle_quiet", 32'(quiet), 32'd1);
        checkOutput("idle_tick_phase_errs", 32'(tick_errs), 32'd0);
        checkOutput("idle_tick_count", 32'(tick_cnt), 32'd25);
        checkOutput("idle_keys1", 32'(keys1), 32'd0);

        for (int i = 0; i < 7; i++) begin
            prev = keys0;
            applyStimulus(vecs[i].raw);
            expectAccept($sformatf("vec%0d", i), prev, vecs[i].exp_keys, vecs[i].exp_press, vecs[i].exp_rel);
        end

        // Bounce key 5, toggling every 5 cycles: never long enough to qualify.
        quiet = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (t % 5 == 0) raw0[5] = ~raw0[5];
            advance();
            if (keys0 !== '0 || press0 !== '0 || rel0 !== '0 || any0 !== 1'b0) quiet = 1'b0;
        end
        checkOutput("bounce_quiet", 32'(quiet), 32'd1);
        checkOutput("bounce_end_level", 32'(raw0[5]), 32'd1);
        applyStimulus(IDLE & ~13'h0020);
        expectAccept("bounce_press", 13'h0000, 13'h0020, 13'h0020, 13'h0000);

        // Reset while key 3 is two ticks into qualification.
        applyStimulus(IDLE & ~13'h0028);
        while (ticks_seen < 2 && n_since < 20) advance();
        checkOutput("midqual_keys", 32'(keys0), 32'h0020);
        nreset = 1'b0;
        advance();
        nreset = 1'b1;
        checkOutput("midreset_keys", 32'(keys0), 32'd0);
        checkOutput("midreset_pulses", 32'({press0, rel0, any0}), 32'd0);
        n_since    = 0;
        ticks_seen = 0;
        expectAccept("requal", 13'h0000, 13'h0028, 13'h0028, 13'h0000);

        // Single-cycle glitch on the PRESCALE=1, STABLE=1 instance.
        raw1[7] = 1'b0;
        advance();
        raw1 = IDLE;
        checkOutput("glitch_p0_keys", 32'(keys1), 32'd0);
        advance();
        checkOutput("glitch_p1_keys", 32'(keys1), 32'd0);
        checkOutput("glitch_tick1", 32'(tick1), 32'd1);
        advance();
        checkOutput("glitch_p2_keys", 32'(keys1), 32'h0080);
        checkOutput("glitch_p2_press", 32'(press1), 32'h0080);
        checkOutput("glitch_p2_rel", 32'(rel1), 32'h0000);
        checkOutput("glitch_p2_any", 32'(any1), 32'd1);
        advance();
        checkOutput("glitch_p3_keys", 32'(keys1), 32'h0000);
        checkOutput("glitch_p3_press", 32'(press1), 32'h0000);
        checkOutput("glitch_p3_rel", 32'(rel1), 32'h0080);
        checkOutput("glitch_p3_any", 32'(any1), 32'd1);
        advance();
        checkOutput("glitch_p4_pulses", 32'({press1, rel1, any1}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
